dac_jesd204_tx_framer: RTL and testbench

Parametrised JESD204 transmit data path for the DAC cores: it accepts channel-major sample beats from the DMA side through a valid/ready handshake and buffers them in a small synchronous FIFO. Each output beat is the buffered samples remapped into lane-major octets, presented to the JESD204 link layer under a real `tx_valid`/`tx_ready` handshake. Compared with the fixed `tx_valid = 1` data path it replaces, it adds:
- a start-up fill threshold,
- per-channel masking,
- underflow substitution and counting,
- generic lane/channel counts.

It sits between the DMA/DAC core datapath and the JESD204 TX link layer, in the `tx_clk` domain.

---
 rtl/dac_jesd204_tx_pkg.sv | 32 +++
 rtl/dac_jesd204_tx_framer_if.sv | 21 ++
 rtl/dac_jesd204_tx_fifo.sv | 74 +++++++
 rtl/dac_jesd204_tx_framer.sv | 163 ++++++++++++++++
 tb/tb_dac_jesd204_tx_framer.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/dac_jesd204_tx_pkg.sv
// Shared types and helpers for the JESD204 transmit framer: FSM states, the
// octet placement function and the FIFO level width helper.
package dac_jesd204_tx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   localparam int SAMPLE_W        = 16;
   localparam int LANE_W          = 32;
   localparam int OCTETS_PER_LANE = LANE_W / 8;

   typedef struct packed {
      int lane;
      int slot;
   } octet_pos_t;

   function automatic int level_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

   // Octet o lands on lane (o mod lanes) in slot (o div lanes); slot 0 is the MSB octet.
   function automatic octet_pos_t octet_map(input int o, input int numLanes);
      octet_pos_t pos;
      pos.lane = o % numLanes;
      pos.slot = o / numLanes;
      return pos;
   endfunction

endpackage

// File: rtl/dac_jesd204_tx_framer_if.sv
// Valid/ready beat stream used for both the DMA-side sample input and the
// link-layer output of the framer.
interface dac_jesd204_tx_framer_if #(
   parameter int WIDTH = 128
);
   logic [WIDTH-1:0] data;
   logic             valid;
   logic             ready;

   modport master (
      output data,
      output valid,
      input  ready
   );

   modport slave (
      input  data,
      input  valid,
      output ready
   );
endinterface

// File: rtl/dac_jesd204_tx_fifo.sv
// Synchronous show-ahead beat FIFO with flush, occupancy level and full/empty flags.
module dac_jesd204_tx_fifo
   import dac_jesd204_tx_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int WIDTH = 128
) (
   input  logic                          clk_i,
   input  logic                          rstn_i,
   input  logic                          flush_i,
   input  logic                          push_i,
   input  logic [WIDTH-1:0]              data_i,
   input  logic                          pop_i,
   output logic [WIDTH-1:0]              data_o,
   output logic [level_width(DEPTH)-1:0] level_o,
   output logic                          full_o,
   output logic                          empty_o
);

   localparam int ADDR_W  = $clog2(DEPTH);
   localparam int LEVEL_W = level_width(DEPTH);
   localparam logic [LEVEL_W-1:0] FULL_LEVEL = LEVEL_W'(DEPTH);

   logic [WIDTH-1:0]   mem_q [DEPTH];
   logic [ADDR_W-1:0]  wrPtr_q, wrPtr_d;
   logic [ADDR_W-1:0]  rdPtr_q, rdPtr_d;
   logic [LEVEL_W-1:0] level_q, level_d;
   logic               doPush;
   logic               doPop;

   assign full_o  = (level_q == FULL_LEVEL);
   assign empty_o = (level_q == '0);
   assign level_o = level_q;
   assign data_o  = mem_q[rdPtr_q];
   assign doPush  = push_i && !full_o && !flush_i;
   assign doPop   = pop_i && !empty_o && !flush_i;

   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      level_d = level_q;
      if (flush_i) begin
         wrPtr_d = '0;
         rdPtr_d = '0;
         level_d = '0;
      end else begin
         if (doPush) wrPtr_d = wrPtr_q + 1'b1;
         if (doPop)  rdPtr_d = rdPtr_q + 1'b1;
         case ({doPush, doPop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         level_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         level_q <= level_d;
      end
   end

   // Storage carries no reset; the level alone decides what is valid.
   always_ff @(posedge clk_i) begin
      if (doPush) mem_q[wrPtr_q] <= data_i;
   end

endmodule

// File: rtl/dac_jesd204_tx_framer.sv
// JESD204 TX framer: buffers channel-major beats, remaps them to lane-major octets
// and streams them with underflow substitution. Optional test ramp: DAC_JESD204_TX_RAMP_EN.
module dac_jesd204_tx_framer
   import dac_jesd204_tx_pkg::*;
#(
   parameter int NUM_LANES           = 4,
   parameter int NUM_CHANNELS        = 2,
   parameter int SAMPLES_PER_CHANNEL = 2 * NUM_LANES / NUM_CHANNELS,
   parameter int FIFO_DEPTH          = 8,
   parameter int START_LEVEL         = 4
) (
   input  logic                               dac_clk,
   input  logic                               dac_rstn,
   input  logic                               enable,
   input  logic [NUM_CHANNELS-1:0]            chan_enable,
`ifdef DAC_JESD204_TX_RAMP_EN
   input  logic                               ramp_enable,
`endif
   dac_jesd204_tx_framer_if.slave             sIf,
   dac_jesd204_tx_framer_if.master            txIf,
   output logic                               underflow,
   output logic [15:0]                        underflow_count,
   output logic [level_width(FIFO_DEPTH)-1:0] fifo_level
);

   localparam int DATA_W      = NUM_LANES * LANE_W;
   localparam int NUM_SAMPLES = NUM_CHANNELS * SAMPLES_PER_CHANNEL;
   localparam int LEVEL_W     = level_width(FIFO_DEPTH);
   localparam logic [LEVEL_W-1:0] START_LVL = LEVEL_W'(START_LEVEL);

   state_t             state_q, state_d;
   logic [DATA_W-1:0]  txData_q, txData_d;
   logic               underflow_q, underflow_d;
   logic [15:0]        count_q, count_d;

   logic [DATA_W-1:0]  fifoData;
   logic [LEVEL_W-1:0] fifoLevel;
   logic               fifoFull;
   logic               fifoEmpty;
   logic               flush;
   logic               pushEn;
   logic               popCycle;
   logic               popEn;
   logic [DATA_W-1:0]  framed;

   assign flush    = !enable || (state_q == ST_IDLE);
   assign popCycle = (state_q == ST_RUN) && enable && txIf.ready;
   assign popEn    = popCycle && !fifoEmpty;
   assign pushEn   = sIf.valid && sIf.ready;

   assign sIf.ready       = (state_q != ST_IDLE) && !fifoFull;
   assign txIf.valid      = (state_q == ST_RUN);
   assign txIf.data       = txData_q;
   assign underflow       = underflow_q;
   assign underflow_count = count_q;
   assign fifo_level      = fifoLevel;

   dac_jesd204_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_W)
   ) u_fifo (
      .clk_i   (dac_clk),
      .rstn_i  (dac_rstn),
      .flush_i (flush),
      .push_i  (pushEn),
      .data_i  (sIf.data),
      .pop_i   (popEn),
      .data_o  (fifoData),
      .level_o (fifoLevel),
      .full_o  (fifoFull),
      .empty_o (fifoEmpty)
   );

   // FILL leaves on the registered level, so tx_valid trails the threshold by one cycle.
   always_comb begin
      state_d = state_q;
      if (!enable) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: state_d = ST_FILL;
            ST_FILL: if (fifoLevel >= START_LVL) state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_IDLE;
         endcase
      end
   end

`ifdef DAC_JESD204_TX_RAMP_EN
   logic [NUM_CHANNELS-1:0][SAMPLE_W-1:0] ramp_q, ramp_d;

   always_comb begin
      ramp_d = ramp_q;
      if (flush) begin
         ramp_d = '0;
      end else if (popEn && ramp_enable) begin
         for (int m = 0; m < NUM_CHANNELS; m++) begin
            ramp_d[m] = ramp_q[m] + 16'(SAMPLES_PER_CHANNEL);
         end
      end
   end

   always_ff @(posedge dac_clk) begin
      if (!dac_rstn) ramp_q <= '0;
      else           ramp_q <= ramp_d;
   end
`endif

   // Frame order j = k*NUM_CHANNELS + m; each sample contributes its high octet first.
   always_comb begin
      int                  m;
      int                  k;
      logic [SAMPLE_W-1:0] sample;
      octet_pos_t          hiPos;
      octet_pos_t          loPos;
      framed = '0;
      m      = 0;
      k      = 0;
      sample = '0;
      hiPos  = '0;
      loPos  = '0;
      for (int j = 0; j < NUM_SAMPLES; j++) begin
         m      = j % NUM_CHANNELS;
         k      = j / NUM_CHANNELS;
         sample = fifoData[(m * SAMPLES_PER_CHANNEL + k) * SAMPLE_W +: SAMPLE_W];
`ifdef DAC_JESD204_TX_RAMP_EN
         if (ramp_enable) sample = ramp_q[m] + 16'(k);
`endif
         if (!chan_enable[m]) sample = '0;
         hiPos = octet_map(2 * j, NUM_LANES);
         loPos = octet_map(2 * j + 1, NUM_LANES);
         framed[hiPos.lane * LANE_W + (OCTETS_PER_LANE - 1 - hiPos.slot) * 8 +: 8] = sample[15:8];
         framed[loPos.lane * LANE_W + (OCTETS_PER_LANE - 1 - loPos.slot) * 8 +: 8] = sample[7:0];
      end
   end

   always_comb begin
      txData_d    = txData_q;
      underflow_d = popCycle && fifoEmpty;
      count_d     = count_q;
      if (flush) begin
         txData_d = '0;
      end else if (popCycle) begin
         txData_d = fifoEmpty ? '0 : framed;
      end
      if (underflow_d && (count_q != 16'hFFFF)) count_d = count_q + 1'b1;
   end

   always_ff @(posedge dac_clk) begin
      if (!dac_rstn) begin
         state_q     <= ST_IDLE;
         txData_q    <= '0;
         underflow_q <= 1'b0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         txData_q    <= txData_d;
         underflow_q <= underflow_d;
         count_q     <= count_d;
      end
   end

endmodule

// File: tb/tb_dac_jesd204_tx_framer.sv
// Directed bench for dac_jesd204_tx_framer (4 lanes, 2 channels, depth 8, start level 4).
// Ramp steps are built only when DAC_JESD204_TX_RAMP_EN is defined.
module tb_dac_jesd204_tx_framer;
   import dac_jesd204_tx_pkg::*;

   localparam int DW = 128;

   logic        clk = 1'b0;
   logic        dac_rstn;
   logic        enable;
   logic [1:0]  chan_enable;
   logic        underflow;
   logic [15:0] underflow_count;
   logic [3:0]  fifo_level;
`ifdef DAC_JESD204_TX_RAMP_EN
   logic        ramp_enable;
`endif

   int vectors;
   int miscompares;

   dac_jesd204_tx_framer_if #(.WIDTH(DW)) sIf ();
   dac_jesd204_tx_framer_if #(.WIDTH(DW)) txIf ();

   dac_jesd204_tx_framer dut (
      .dac_clk         (clk),
      .dac_rstn        (dac_rstn),
      .enable          (enable),
      .chan_enable     (chan_enable),
`ifdef DAC_JESD204_TX_RAMP_EN
      .ramp_enable     (ramp_enable),
`endif
      .sIf             (sIf),
      .txIf            (txIf),
      .underflow       (underflow),
      .underflow_count (underflow_count),
      .fifo_level      (fifo_level)
   );

   always #5 clk = ~clk;

   // Beat b>1 uses bytes A_k=b0+k, B_k=b4+k (ch0 hi/lo) and C_k=b8+k, D_k=bC+k (ch1 hi/lo).
   function automatic logic [127:0] beatIn(input int b);
      logic [127:0] d;
      logic [7:0]   base;
      if (b == 1) return 128'h0F10_0B0C_0D0E_090A_0708_0304_0506_0102;
      base = 8'(b * 16);
      d    = '0;
      for (int k = 0; k < 4; k++) begin
         d[k * 16 +: 16]       = {base + 8'(k), base + 8'(4 + k)};
         d[(4 + k) * 16 +: 16] = {base + 8'(8 + k), base + 8'(12 + k)};
      end
      return d;
   endfunction

   // Lane 0 carries ch0 high bytes, lane 1 ch0 low, lane 2 ch1 high, lane 3 ch1 low.
   function automatic logic [127:0] beatOut(input int b);
      logic [127:0] d;
      logic [7:0]   base;
      if (b == 1) return 128'h0A0E0C10_090D0B0F_02060408_01050307;
      base = 8'(b * 16);
      d    = '0;
      for (int l = 0; l < 4; l++) begin
         for (int t = 0; t < 4; t++) begin
            d[l * 32 + (3 - t) * 8 +: 8] = base + 8'(4 * l + t);
         end
      end
      return d;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic valid, input logic [127:0] data, input logic ready);
      sIf.valid  = valid;
      sIf.data   = data;
      txIf.ready = ready;
      tick();
   endtask

   task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   initial begin
      int           fillLevel [6];
      logic         fillValid [6];
      logic [127:0] exp;

      fillLevel   = '{1, 2, 3, 4, 5, 5};
      fillValid   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      vectors     = 0;
      miscompares = 0;
      dac_rstn    = 1'b0;
      enable      = 1'b0;
      chan_enable = 2'b11;
      sIf.valid   = 1'b0;
      sIf.data    = '0;
      txIf.ready  = 1'b0;
`ifdef DAC_JESD204_TX_RAMP_EN
      ramp_enable = 1'b0;
`endif
      tick();
      tick();
      checkOutput("rst_tx_valid", 128'(txIf.valid), 128'd0);
      checkOutput("rst_tx_data", txIf.data, 128'd0);
      checkOutput("rst_s_ready", 128'(sIf.ready), 128'd0);
      checkOutput("rst_underflow", 128'(underflow), 128'd0);
      checkOutput("rst_count", 128'(underflow_count), 128'd0);
      checkOutput("rst_level", 128'(fifo_level), 128'd0);

      $display("[TB] enable with no input");
      dac_rstn = 1'b1;
      enable   = 1'b1;
      tick();
      checkOutput("fill_s_ready", 128'(sIf.ready), 128'd1);
      checkOutput("fill_tx_valid", 128'(txIf.valid), 128'd0);
      checkOutput("fill_level", 128'(fifo_level), 128'd0);
      tick();
      checkOutput("fill_tx_valid_hold", 128'(txIf.valid), 128'd0);

      $display("[TB] fill and stream");
      for (int b = 1; b <= 6; b++) begin
         applyStimulus(1'b1, beatIn(b), 1'b1);
         checkOutput($sformatf("fill_level_%0d", b), 128'(fifo_level), 128'(fillLevel[b-1]));
         checkOutput($sformatf("fill_valid_%0d", b), 128'(txIf.valid), 128'(fillValid[b-1]));
         if (b == 5) checkOutput("run_first_zero", txIf.data, 128'd0);
      end
      checkOutput("beat1_data", txIf.data, beatOut(1));
      checkOutput("beat1_lane0", 128'(txIf.data[31:0]), 128'h01050307);

      $display("[TB] backpressure");
      for (int b = 7; b <= 9; b++) begin
         applyStimulus(1'b1, beatIn(b), 1'b0);
         checkOutput($sformatf("bp_level_%0d", b), 128'(fifo_level), 128'(b - 1));
         checkOutput($sformatf("bp_hold_%0d", b), txIf.data, beatOut(1));
      end
      checkOutput("bp_s_ready_full", 128'(sIf.ready), 128'd0);
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b1, beatIn(9), 1'b0);
         checkOutput("bp_full_level", 128'(fifo_level), 128'd8);
         checkOutput("bp_full_hold", txIf.data, beatOut(1));
      end
      for (int b = 2; b <= 9; b++) begin
         applyStimulus(1'b0, '0, 1'b1);
         checkOutput($sformatf("drain_data_%0d", b), txIf.data, beatOut(b));
         checkOutput($sformatf("drain_level_%0d", b), 128'(fifo_level), 128'(9 - b));
      end

      $display("[TB] underflow");
      for (int i = 1; i <= 3; i++) begin
         applyStimulus(1'b0, '0, 1'b1);
         checkOutput("uf_data", txIf.data, 128'd0);
         checkOutput("uf_pulse", 128'(underflow), 128'd1);
         checkOutput("uf_count", 128'(underflow_count), 128'(i));
         checkOutput("uf_tx_valid", 128'(txIf.valid), 128'd1);
      end
      applyStimulus(1'b0, '0, 1'b0);
      checkOutput("uf_pulse_clear", 128'(underflow), 128'd0);
      checkOutput("uf_count_hold", 128'(underflow_count), 128'd3);

      $display("[TB] channel mask and flush");
      chan_enable = 2'b10;
      applyStimulus(1'b1, beatIn(2), 1'b0);
      checkOutput("mask_level", 128'(fifo_level), 128'd1);
      applyStimulus(1'b0, '0, 1'b1);
      exp        = beatOut(2);
      exp[63:0]  = '0;
      checkOutput("mask_data", txIf.data, exp);
      checkOutput("mask_no_uf", 128'(underflow), 128'd0);
      chan_enable = 2'b11;
      applyStimulus(1'b1, beatIn(3), 1'b0);
      applyStimulus(1'b1, beatIn(4), 1'b0);
      checkOutput("pre_flush_level", 128'(fifo_level), 128'd2);
      sIf.valid = 1'b0;
      enable    = 1'b0;
      tick();
      checkOutput("flush_level", 128'(fifo_level), 128'd0);
      checkOutput("flush_tx_valid", 128'(txIf.valid), 128'd0);
      checkOutput("flush_tx_data", txIf.data, 128'd0);
      checkOutput("flush_s_ready", 128'(sIf.ready), 128'd0);
      checkOutput("flush_count_kept", 128'(underflow_count), 128'd3);

      $display("[TB] reset during RUN");
      enable = 1'b1;
      tick();
      for (int b = 2; b <= 5; b++) applyStimulus(1'b1, beatIn(b), 1'b0);
      applyStimulus(1'b0, '0, 1'b0);
      checkOutput("mid_run_valid", 128'(txIf.valid), 128'd1);
      dac_rstn = 1'b0;
      tick();
      checkOutput("mid_rst_valid", 128'(txIf.valid), 128'd0);
      checkOutput("mid_rst_level", 128'(fifo_level), 128'd0);
      checkOutput("mid_rst_count", 128'(underflow_count), 128'd0);
      checkOutput("mid_rst_s_ready", 128'(sIf.ready), 128'd0);
      dac_rstn = 1'b1;

      $display("[TB] underflow count saturation");
      tick();
      for (int b = 2; b <= 5; b++) applyStimulus(1'b1, beatIn(b), 1'b0);
      applyStimulus(1'b0, '0, 1'b0);
      for (int b = 2; b <= 5; b++) applyStimulus(1'b0, '0, 1'b1);
      checkOutput("sat_last_beat", txIf.data, beatOut(5));
      checkOutput("sat_count_start", 128'(underflow_count), 128'd0);
      for (int i = 0; i < 65534; i++) applyStimulus(1'b0, '0, 1'b1);
      checkOutput("sat_count_fffe", 128'(underflow_count), 128'hFFFE);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b1);
      checkOutput("sat_count_ffff", 128'(underflow_count), 128'hFFFF);
      checkOutput("sat_pulse", 128'(underflow), 128'd1);

`ifdef DAC_JESD204_TX_RAMP_EN
      $display("[TB] ramp");
      enable = 1'b0;
      tick();
      enable = 1'b1;
      tick();
      for (int b = 2; b <= 5; b++) applyStimulus(1'b1, beatIn(b), 1'b0);
      applyStimulus(1'b0, '0, 1'b0);
      ramp_enable = 1'b1;
      applyStimulus(1'b0, '0, 1'b1);
      checkOutput("ramp_beat0", txIf.data, 128'h00010203_00000000_00010203_00000000);
      applyStimulus(1'b0, '0, 1'b1);
      checkOutput("ramp_beat1", txIf.data, 128'h04050607_00000000_04050607_00000000);
      ramp_enable = 1'b0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
